// File: rtl/uart_pkg.sv
// Types and helpers shared by the UART receive and transmit stages.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam logic STOP_LEVEL = 1'b1;

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_START = 5'b00010,
    S_DATA  = 5'b00100,
    S_STOP  = 5'b01000,
    S_BREAK = 5'b10000
  } rx_state_t;

  function automatic int unsigned bit_cycles(input int unsigned clk_freq,
                                             input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit; reset value selectable.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with valid/ack handshake, framing and overrun flags.
// Define RX_MAJORITY_EN to take a 2-of-3 vote over the last three line samples.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUDRATE = 57600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       data_in,
  input  logic       rx_ack,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       rx_busy
);

  localparam int unsigned BitCycles  = bit_cycles(CLK_FREQ, BAUDRATE);
  localparam int unsigned HalfCycles = BitCycles / 2;
  localparam int unsigned CntW       = $clog2(BitCycles + 1);
  localparam int unsigned IdxW       = $clog2(DATA_BITS);
  localparam logic [CntW-1:0] BitLast  = CntW'(BitCycles - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(HalfCycles - 1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(DATA_BITS - 1);

  rx_state_t            state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [7:0]           byte_q, byte_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 line_s;
  logic                 sample;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (data_in),
    .q     (line_s)
  );

`ifdef RX_MAJORITY_EN
  // hist_q[0] holds line_s from one cycle ago, hist_q[1] from two cycles ago.
  logic [1:0] hist_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], line_s};
    end
  end

  assign sample = (hist_q[0] & hist_q[1]) | (hist_q[0] & line_s) | (hist_q[1] & line_s);
`else
  assign sample = line_s;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    if (rx_ack) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (!line_s) begin
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == HalfLast) begin
          idx_d   = '0;
          state_d = sample ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == BitLast) begin
          shift_d = {sample, shift_q[DATA_BITS-1:1]};
          idx_d   = idx_q + IdxW'(1);
          if (idx_q == IdxLast) begin
            state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (cnt_q == BitLast) begin
          if (sample == STOP_LEVEL) begin
            // A same-cycle ack consumes the old byte, so the new one is not an overrun.
            byte_d  = shift_q;
            ovr_d   = valid_q & ~rx_ack;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (line_s) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q || cnt_q == BitLast) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_byte   = byte_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign rx_busy   = (state_q != S_IDLE);

endmodule
